sid_write_arbiter: RTL

- Shares the single SID register write port between two requesters:
  - the C64 bus interface (bus write strobe);
  - a USB CDC byte stream (register-write packets).
- The bus always wins. Stream writes are parsed, buffered in a FIFO, and issued one per clk_en period, only in gaps left by the bus.
- Sits between sid_bus_if / the USB CDC out stream and the sid core's WR/ADDR/DATAW inputs.

---
 rtl/sid_write_arbiter_if.sv | 56 +++++
 rtl/sid_write_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sid_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sid_write_arbiter_if
// Description : Bus, stream and SID-side signals of the SID write arbiter.
//               The slave modport is the arbiter; the master modport is the
//               surrounding system (C64 bus, USB CDC stream, SID core).
//               Shadow-read signals exist only when SID_SHADOW_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface sid_write_arbiter_if #(
  parameter int LW = 5
);
  logic          clk_en;
  logic          bus_we;
  logic [4:0]    bus_addr;
  logic [7:0]    bus_wdata;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic          sid_we;
  logic [4:0]    sid_addr;
  logic [7:0]    sid_wdata;
  logic          sid_src;
  logic [LW-1:0] fifo_level;
  logic          frame_err;
`ifdef SID_SHADOW_EN
  logic [4:0]    shadow_addr;
  logic [8:0]    shadow_data;

  modport master (
    output clk_en, bus_we, bus_addr, bus_wdata, s_data, s_last, s_valid,
    output shadow_addr,
    input  s_ready, sid_we, sid_addr, sid_wdata, sid_src, fifo_level,
    input  frame_err, shadow_data
  );
  modport slave (
    input  clk_en, bus_we, bus_addr, bus_wdata, s_data, s_last, s_valid,
    input  shadow_addr,
    output s_ready, sid_we, sid_addr, sid_wdata, sid_src, fifo_level,
    output frame_err, shadow_data
  );
`else
  modport master (
    output clk_en, bus_we, bus_addr, bus_wdata, s_data, s_last, s_valid,
    input  s_ready, sid_we, sid_addr, sid_wdata, sid_src, fifo_level,
    input  frame_err
  );
  modport slave (
    input  clk_en, bus_we, bus_addr, bus_wdata, s_data, s_last, s_valid,
    output s_ready, sid_we, sid_addr, sid_wdata, sid_src, fifo_level,
    output frame_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sid_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sid_write_arbiter
// Description : Shares the SID register write port between the C64 bus
//               (always wins) and a USB CDC stream of {addr,data} packets.
//               Stream writes are parsed, queued in a FIFO and issued at
//               most once per clk_en pulse, only when the bus is idle.
//               Optional feature macro: SID_SHADOW_EN (32x9 shadow file
//               with a registered read port).
// Revision    : 1.0 - initial release
// ============================================================================
module sid_write_arbiter #(
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  wire                clk,
  input  wire                rst,
  sid_write_arbiter_if.slave bus
);
  localparam int            AW         = $clog2(DEPTH);
  localparam logic [0:0]    c_ST_ADDR  = 1'b0;
  localparam logic [0:0]    c_ST_DATA  = 1'b1;
  localparam logic [LW-1:0] c_FULL     = LW'(DEPTH);

  logic [0:0]    state_q, state_d;
  logic [4:0]    pend_addr_q;
  logic          frame_err_q;
  logic          alive_q;
  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          sid_we_q, sid_src_q;
  logic [4:0]    sid_addr_q;
  logic [7:0]    sid_wdata_q;

  logic          w_ready, w_accept, w_pop;
  logic          w_push, w_ferr, w_load;
  logic [12:0]   w_head;

  // Ready is held low through reset by alive_q, otherwise depends only on FIFO fill.
  assign w_ready  = alive_q & (level_q != c_FULL);
  assign w_accept = bus.s_valid & w_ready;
  // The bus has priority; a stream pop only uses a clk_en slot the bus leaves free.
  assign w_pop    = bus.clk_en & ~bus.bus_we & (level_q != '0);
  assign w_head   = mem_q[rd_ptr_q];

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_ST_ADDR;
    else     state_q <= state_d;
  end

  // Parser next state: an address byte opens a packet, a last byte closes it.
  always_comb begin
    state_d = state_q;
    if (w_accept) begin
      case (state_q)
        c_ST_ADDR: if (!bus.s_last) state_d = c_ST_DATA;
        c_ST_DATA: if (bus.s_last)  state_d = c_ST_ADDR;
        default:   state_d = c_ST_ADDR;
      endcase
    end
  end

  // Parser outputs: push on complete packet, framing error on misplaced last flag.
  always_comb begin
    w_push = 1'b0;
    w_ferr = 1'b0;
    w_load = 1'b0;
    if (w_accept) begin
      case (state_q)
        c_ST_ADDR: begin
          w_ferr = bus.s_last;
          w_load = ~bus.s_last;
        end
        c_ST_DATA: begin
          w_push = bus.s_last;
          w_ferr = ~bus.s_last;
          w_load = ~bus.s_last;
        end
        default: ;
      endcase
    end
  end

  // Pending address, framing-error pulse and post-reset ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_addr_q <= '0;
      frame_err_q <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      if (w_load) pend_addr_q <= bus.s_data[4:0];
      frame_err_q <= w_ferr;
      alive_q     <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {pend_addr_q, bus.s_data};
  end

  // FIFO pointers (wrap naturally at DEPTH) and fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Registered SID write port: bus write first, else a popped stream entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sid_we_q    <= 1'b0;
      sid_src_q   <= 1'b0;
      sid_addr_q  <= '0;
      sid_wdata_q <= '0;
    end else if (bus.bus_we) begin
      sid_we_q    <= 1'b1;
      sid_src_q   <= 1'b0;
      sid_addr_q  <= bus.bus_addr;
      sid_wdata_q <= bus.bus_wdata;
    end else if (w_pop) begin
      sid_we_q    <= 1'b1;
      sid_src_q   <= 1'b1;
      sid_addr_q  <= w_head[12:8];
      sid_wdata_q <= w_head[7:0];
    end else begin
      sid_we_q    <= 1'b0;
    end
  end

  assign bus.s_ready    = w_ready;
  assign bus.sid_we     = sid_we_q;
  assign bus.sid_src    = sid_src_q;
  assign bus.sid_addr   = sid_addr_q;
  assign bus.sid_wdata  = sid_wdata_q;
  assign bus.fifo_level = level_q;
  assign bus.frame_err  = frame_err_q;

`ifdef SID_SHADOW_EN
  logic [8:0] shadow_q [32];
  logic [8:0] shadow_data_q;

  // Shadow copy of every issued write; bit 8 flags "written since reset".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
      shadow_data_q <= '0;
    end else begin
      if (sid_we_q) shadow_q[sid_addr_q] <= {1'b1, sid_wdata_q};
      shadow_data_q <= shadow_q[bus.shadow_addr];
    end
  end

  assign bus.shadow_data = shadow_data_q;
`endif

endmodule
`default_nettype wire
